// File: rtl/uart_bus_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART bus master.
package uart_bus_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h57;
    localparam logic [7:0] CMD_READ   = 8'h52;
    localparam logic [7:0] CMD_PING   = 8'h50;

    localparam logic [7:0] RSP_OK     = 8'h4B;
    localparam logic [7:0] RSP_ERR    = 8'h45;
    localparam logic [7:0] RSP_BADCMD = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/uart_tx_seq.sv
// Response sequencer: sends up to five bytes, byte 0 first, one tx_write per byte
// and waits for tx_finished before the next; done pulses on the last tx_finished.
module uart_tx_seq (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [39:0] bytes,
    input  logic [2:0]  count,
    input  logic        tx_finished,
    output logic        tx_write,
    output logic [7:0]  tx_data,
    output logic        done
);

    logic [39:0] buf_q, buf_d;
    logic [2:0]  left_q, left_d;
    logic        active_q, active_d;
    logic        tx_write_q, tx_write_d;

    always_comb begin
        buf_d      = buf_q;
        left_d     = left_q;
        active_d   = active_q;
        tx_write_d = 1'b0;
        done       = 1'b0;
        if (start) begin
            buf_d      = bytes;
            left_d     = count;
            active_d   = 1'b1;
            tx_write_d = 1'b1;
        end else if (active_q && !tx_write_q && tx_finished) begin
            // a tx_finished coinciding with our own tx_write belongs to nothing we sent
            if (left_q == 3'd1) begin
                active_d = 1'b0;
                left_d   = 3'd0;
                done     = 1'b1;
            end else begin
                buf_d      = buf_q >> 8;
                left_d     = left_q - 3'd1;
                tx_write_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            buf_q      <= '0;
            left_q     <= '0;
            active_q   <= 1'b0;
            tx_write_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            left_q     <= left_d;
            active_q   <= active_d;
            tx_write_q <= tx_write_d;
        end
    end

    assign tx_write = tx_write_q;
    assign tx_data  = buf_q[7:0];

endmodule

// File: rtl/uart_bus_master.sv
// UART command parser that issues word reads/writes on the picorv32 native bus.
// state   | meaning
// IDLE    | waiting for an opcode byte
// ADDR    | shifting in 4 address bytes, LSB first
// DATA    | shifting in 4 write-data bytes, LSB first
// BUS     | mem_valid raised from the 2nd cycle, held until mem_ready or timeout
// RESP    | tx sequencer sending the response bytes
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int CLK_FREQ    = 12000000,
    parameter int RX_TIMEOUT  = 1200000,
    parameter int BUS_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        tx_write,
    output logic [7:0]  tx_data,
    input  logic        tx_finished,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int RXW = ($clog2(RX_TIMEOUT + 1) > 21) ? $clog2(RX_TIMEOUT + 1) : 21;
    localparam int BW  = $clog2(BUS_TIMEOUT + 1);
    localparam logic [RXW-1:0] RX_RELOAD  = RXW'(RX_TIMEOUT - 1);
    localparam logic [BW-1:0]  BUS_RELOAD = BW'(BUS_TIMEOUT - 1);

    if (CLK_FREQ < 1 || RX_TIMEOUT < 2 || BUS_TIMEOUT < 2) begin : g_bad_param
        $error("uart_bus_master: CLK_FREQ must be positive and both timeouts at least 2");
    end

    state_e         state_q, state_d;
    logic           wr_q, wr_d;
    logic [31:2]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [1:0]     nbyte_q, nbyte_d;
    logic [RXW-1:0] rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]  bus_cnt_q, bus_cnt_d;
    logic           mem_valid_q, mem_valid_d;

    logic           seq_start;
    logic [39:0]    seq_bytes;
    logic [2:0]     seq_count;
    logic           seq_done;

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        nbyte_d     = nbyte_q;
        rx_cnt_d    = rx_cnt_q;
        bus_cnt_d   = bus_cnt_q;
        mem_valid_d = mem_valid_q;
        seq_start   = 1'b0;
        seq_bytes   = {32'h0, RSP_OK};
        seq_count   = 3'd1;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_ready) begin
                    nbyte_d  = 2'd0;
                    rx_cnt_d = RX_RELOAD;
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        wr_d    = (rx_data == CMD_WRITE);
                        state_d = ST_ADDR;
                    end else begin
                        seq_start = 1'b1;
                        if (rx_data != CMD_PING) seq_bytes = {32'h0, RSP_BADCMD};
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ADDR, ST_DATA: begin
                if (rx_ready) begin
                    rx_cnt_d = RX_RELOAD;
                    nbyte_d  = nbyte_q + 2'd1;
                    if (state_q == ST_ADDR) addr_d = {rx_data, addr_q[31:10]};
                    else                    wdata_d = {rx_data, wdata_q[31:8]};
                    if (nbyte_q == 2'd3)
                        state_d = (state_q == ST_ADDR && wr_q) ? ST_DATA : ST_BUS;
                end else if (rx_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - RXW'(1);
                end
            end
            ST_BUS: begin
                if (!mem_valid_q) begin
                    mem_valid_d = 1'b1;
                    bus_cnt_d   = BUS_RELOAD;
                end else if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    seq_start   = 1'b1;
                    if (!wr_q) begin
                        seq_bytes = {mem_rdata, RSP_OK};
                        seq_count = 3'd5;
                    end
                    state_d = ST_RESP;
                end else if (bus_cnt_q == '0) begin
                    mem_valid_d = 1'b0;
                    seq_start   = 1'b1;
                    seq_bytes   = {32'h0, RSP_ERR};
                    state_d     = ST_RESP;
                end else begin
                    bus_cnt_d = bus_cnt_q - BW'(1);
                end
            end
            ST_RESP: begin
                if (seq_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            nbyte_q     <= '0;
            rx_cnt_q    <= '0;
            bus_cnt_q   <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            nbyte_q     <= nbyte_d;
            rx_cnt_q    <= rx_cnt_d;
            bus_cnt_q   <= bus_cnt_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    uart_tx_seq u_tx_seq (
        .clk         (clk),
        .n_reset     (n_reset),
        .start       (seq_start),
        .bytes       (seq_bytes),
        .count       (seq_count),
        .tx_finished (tx_finished),
        .tx_write    (tx_write),
        .tx_data     (tx_data),
        .done        (seq_done)
    );

    assign mem_valid = mem_valid_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_wstrb = (mem_valid_q && wr_q) ? 4'hF : 4'h0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: ping, write, read, bus timeout, bad opcode,
// rx timeout and asynchronous reset during a bus access.
module tb_uart_bus_master;

    localparam int RXT = 200;
    localparam int BST = 1024;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic        tx_finished;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int fin_cnt = 0;
    bit valid_seen = 1'b0;
    logic [7:0] tx_log[$];

    uart_bus_master #(.RX_TIMEOUT(RXT), .BUS_TIMEOUT(BST)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_write    (tx_write),
        .tx_data     (tx_data),
        .tx_finished (tx_finished),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART core model: records each byte and answers tx_finished 4 cycles later.
    initial begin
        tx_finished = 1'b0;
        forever begin
            @(negedge clk);
            tx_finished = 1'b0;
            if (fin_cnt == 1) tx_finished = 1'b1;
            if (fin_cnt > 0) fin_cnt--;
            if (mem_valid) valid_seen = 1'b1;
            if (tx_write) begin
                check_eq("tx_after_finished", fin_cnt, 0);
                tx_log.push_back(tx_data);
                fin_cnt = 4;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_serve(input string tag, input int delay, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_wstrb, input bit is_write);
        int t = 0;
        int vc = 0;
        while (!mem_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_valid"}, mem_valid, 1);
        check_eq({tag, "_addr"}, mem_addr, exp_addr);
        check_eq({tag, "_wstrb"}, mem_wstrb, exp_wstrb);
        if (is_write) check_eq({tag, "_wdata"}, mem_wdata, exp_wdata);
        for (int i = 0; i < delay; i++) begin
            if (mem_valid) vc++;
            @(negedge clk);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        if (mem_valid) vc++;
        check_eq({tag, "_addr_stable"}, mem_addr, exp_addr);
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check_eq({tag, "_valid_cycles"}, vc, delay + 1);
        check_eq({tag, "_valid_drop"}, mem_valid, 0);
    endtask

    task automatic expect_tx(input string tag, input int n, input logic [39:0] exp);
        int t = 0;
        logic [39:0] e;
        while ((busy || tx_log.size() < n) && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        check_eq({tag, "_tx_count"}, tx_log.size(), n);
        e = exp;
        for (int i = 0; i < n && i < tx_log.size(); i++) begin
            check_eq($sformatf("%s_tx_byte%0d", tag, i), tx_log[i], e[7:0]);
            e = e >> 8;
        end
        check_eq({tag, "_busy_low"}, busy, 0);
        tx_log.delete();
    endtask

    task automatic ping(input string tag);
        valid_seen = 1'b0;
        send_byte(8'h50);
        check_eq({tag, "_busy_high"}, busy, 1);
        expect_tx(tag, 1, 40'h4B);
        check_eq({tag, "_no_bus"}, valid_seen, 0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", mem_valid, 0);
        check_eq("rst_tx_write", tx_write, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wstrb", mem_wstrb, 0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        ping("ping");

        // stray acknowledge with no request outstanding
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check_eq("stray_ready_idle", busy, 0);

        send_byte(8'h57);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        bus_serve("wr", 3, 32'h0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
        expect_tx("wr", 1, 40'h4B);

        send_byte(8'h52);
        send_byte(8'h06); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        bus_serve("rd", 1, 32'h1234_5678, 32'h0100_0004, 32'h0, 4'h0, 1'b0);
        // bytes arriving during the response are dropped
        send_byte(8'h50);
        expect_tx("rd", 5, 40'h12_34_56_78_4B);

        send_byte(8'h52);
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        k = 0;
        while (!mem_valid && k < 50) begin @(negedge clk); k++; end
        k = 0;
        while (mem_valid && k < 2 * BST) begin @(negedge clk); k++; end
        check_eq("bto_valid_cycles", k, BST);
        expect_tx("bto", 1, 40'h45);

        send_byte(8'hAA);
        expect_tx("bad", 1, 40'h3F);

        send_byte(8'h57);
        send_byte(8'h01);
        k = 0;
        while (busy && k < RXT + 50) begin @(negedge clk); k++; end
        check_eq("rxto_window", (k >= RXT - 3 && k <= RXT + 1), 1);
        check_eq("rxto_busy_low", busy, 0);
        repeat (10) @(negedge clk);
        check_eq("rxto_no_tx", tx_log.size(), 0);
        ping("ping_after_rxto");

        send_byte(8'h52);
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        k = 0;
        while (!mem_valid && k < 50) begin @(negedge clk); k++; end
        check_eq("rst_mid_valid_pre", mem_valid, 1);
        repeat (2) @(negedge clk);
        #2 n_reset = 1'b0;
        #1;
        check_eq("rst_mid_valid", mem_valid, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_tx_write", tx_write, 0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        ping("ping_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-driven bus initiator (debug/loader bridge); the host-side counterpart of the CPU-facing UART peripheral.
- Consumes bytes from the UART core's rx byte interface and parses framed commands.
- Issues word reads and writes on the picorv32 native memory bus as a master, then returns status and data bytes through the UART core's tx interface.
- Sits beside the CPU on the bus arbiter; used to load RAM and poke peripherals without CPU involvement.

Parameters:
- CLK_FREQ, 12000000, clock frequency in Hz; informational only, not used in timeout math.
- RX_TIMEOUT, 1200000, idle cycles between command bytes before the parser discards the partial frame (100 ms at 12 MHz).
- BUS_TIMEOUT, 1024, cycles to wait for mem_ready before aborting a bus access.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- rx_ready  in  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  in  8  received byte.
- tx_write  out  1  one-cycle pulse: send tx_data.
- tx_data  out  8  byte to transmit.
- tx_finished  in  1  one-cycle pulse: previous byte fully shifted out.
- mem_valid  out  1  bus request.
- mem_addr  out  32  word address; bits [1:0] are forced to 0.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'hF for write, 4'h0 for read.
- mem_ready  in  1  bus acknowledge.
- mem_rdata  in  32  read data, valid while mem_ready is high.
- busy  out  1  high from the first byte of an accepted command until its last response byte finishes.

Behaviour:
- Reset: asynchronous on n_reset low. All outputs are 0; the FSM goes to IDLE; shift registers are cleared. Reset mid-operation drops any bus access and tx sequence immediately.
- Commands, little-endian multi-byte fields:
  - 0x57 'W': 4 address bytes, then 4 data bytes. Issues a bus write, then responds 'K' (0x4B).
  - 0x52 'R': 4 address bytes. Issues a bus read, then responds 'K' followed by 4 data bytes, LSB first.
  - 0x50 'P' (ping): responds 'K' with no bus access.
  - Any other command byte: responds '?' (0x3F).
- FSM states:
  - IDLE: the first rx_ready latches the opcode. W/R go to ADDR; P/other go to RESP. busy is set.
  - ADDR: collects 4 bytes into mem_addr, shifting in at [31:24] and shifting right. Then W goes to DATA and R goes to BUS.
  - DATA: collects 4 bytes into mem_wdata the same way, then goes to BUS.
  - BUS: mem_valid is asserted the cycle after entry and held with stable addr/wdata/wstrb until mem_ready is sampled high.
    - On mem_ready: mem_valid drops in the same edge; for a read, mem_rdata is captured; go to RESP.
    - If mem_ready is not seen after BUS_TIMEOUT cycles of mem_valid: drop mem_valid and respond 'E' (0x45) only.
  - RESP: sends the response bytes in sequence. For each byte, tx_write is pulsed for exactly one cycle with tx_data stable, then the FSM waits for tx_finished. After the last byte's tx_finished: clear busy and go to IDLE.
- RX timeout: in ADDR or DATA, a 21-bit-or-wider counter reloads on every rx_ready. When it reaches RX_TIMEOUT, the frame is discarded, the FSM returns to IDLE, and nothing is transmitted.
- Bytes arriving during BUS or RESP are ignored, not queued.
- rx_ready and tx_finished in the same cycle are handled independently; no byte is lost in a state that expects it.
- A mem_ready that arrives while mem_valid is low is ignored.
- Address bits [1:0] received from the host are discarded; accesses are word-aligned.

Decomposition:
- Shared package (uart_bus_pkg):
  - Opcode constants CMD_WRITE, CMD_READ, CMD_PING.
  - Response constants RSP_OK, RSP_ERR, RSP_BADCMD.
  - FSM state enum.
- One natural sub-module, uart_tx_seq: loads up to 5 bytes plus a count, generates the tx_write pulse and waits on tx_finished, and raises done. It keeps the RESP sequencing out of the main FSM.

Test Plan:
- Ping: rx 0x50 -> one tx_write with tx_data=0x4B; no mem_valid; busy falls after tx_finished.
- Write: rx 57 10 00 00 00 EF BE AD DE -> mem_valid with mem_addr=0x00000010, mem_wdata=0xDEADBEEF, mem_wstrb=F. Hold mem_ready low 3 cycles then pulse it -> mem_valid held 4 cycles, then tx 0x4B.
- Read: rx 52 06 00 00 01, with mem_rdata=0x12345678 on mem_ready -> mem_addr=0x01000004, wstrb=0, tx sequence 4B 78 56 34 12, each tx_write only after the prior tx_finished.
- Bus timeout: R command with mem_ready never asserted -> mem_valid drops after BUS_TIMEOUT cycles, single tx 0x45, FSM back in IDLE.
- Bad opcode / RX timeout: rx 0xAA -> tx 0x3F. Separately, rx 57 01 then silence for RX_TIMEOUT cycles -> no tx and busy low; a following ping is answered 0x4B.
- Reset mid-read: assert n_reset during BUS -> mem_valid, tx_write and busy go 0 asynchronously; a subsequent ping works.
